alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
- Sequential issue/writeback controller for RV32I register-register and register-immediate integer ops. It is the initiator side of the ALU interface.
- Accepts one instruction per valid/ready handshake, decodes it into an ALU function code and operands, and reads operands from an internal 32x32 register file.
- Drives the combinational ALU, captures the ALU result, writes it to rd, and reports completion on a valid/ready response channel.
- Sits between the fetch buffer and the ALU in the multi-cycle core variant.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, architectural register count; x0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  32  RV32I instruction word.
- alu_func  out  5  ALU function code: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_out  in  32  ALU result; combinational from alu_func/alu_a/alu_b in the same cycle.
- rsp_valid  out  1  completion response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rd  out  5  destination register of the completed instruction.
- rsp_value  out  32  value written; 0 when illegal.
- rsp_illegal  out  1  instruction was not decodable; no write was performed.
- dbg_addr  in  5  register-file debug read address.
- dbg_data  out  32  combinational read of reg[dbg_addr]; x0 always reads 0.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst_n=0): state=IDLE, all registers x1..x31=0, instr_ready=1, rsp_valid=0, rsp_rd=0, rsp_value=0, rsp_illegal=0, alu_func=NOP, alu_a=0, alu_b=0.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and decode.
  - Legal instruction -> EXEC. Illegal instruction -> RESP with rsp_illegal=1, rsp_value=0, rsp_rd=instr[11:7].
- EXEC (exactly 1 cycle):
  - instr_ready=0. alu_func, alu_a and alu_b are driven from the latched decode.
  - At the clock edge, alu_out is captured into rsp_value and written to reg[rd] unless rd=0. Then -> RESP.
- RESP:
  - rsp_valid=1. rsp_* fields are held stable until rsp_valid&&rsp_ready.
  - On that handshake -> IDLE. instr_ready rises in the next cycle (no same-cycle accept in RESP).
- Outside EXEC: alu_func=NOP (0), alu_a=0, alu_b=0.
- Latency and throughput: accept at cycle N, EXEC at N+1, rsp_valid at N+2. With rsp_ready held at 1, one instruction completes every 3 cycles. Illegal instructions respond at N+1.
- Decode for OP (opcode 0110011), alu_a=reg[rs1], alu_b=reg[rs2]:
  - f3=000: f7=0000000 -> ADD; f7=0100000 -> SUB.
  - f3=001 -> SLL; f3=010 -> SLT; f3=011 -> SLTU; f3=100 -> XOR.
  - f3=101: f7=0000000 -> SRL; f7=0100000 -> SRA.
  - f3=110 -> OR; f3=111 -> AND.
  - Any other funct7 value is illegal.
- Decode for OP-IMM (opcode 0010011), alu_a=reg[rs1], alu_b=sign-extended instr[31:20]:
  - f3 maps to the same functions as OP, except f3=000 is ADD only.
  - Shifts (f3=001, 101) use instr[24:20] zero-extended as alu_b.
  - Shift funct7 must be 0000000, or 0100000 for SRAI only; anything else is illegal.
- Decode for LUI (opcode 0110111): ADD with alu_a=0, alu_b={instr[31:12],12'b0}.
- All other opcodes are illegal.
- Operand reads:
  - Register reads happen at decode time in IDLE; operands are latched at accept.
  - No hazard exists, because writeback completes before the next accept.
- x0: writes are discarded; reads return 0, including rs1/rs2=0 and dbg_addr=0.
- Reset mid-operation (EXEC or RESP): abort immediately. No write occurs if rst_n asserts before the EXEC edge. All state returns to reset values.
- instr_valid while not ready: ignored. instr is not sampled.

Test Plan:
- Reset, then LUI x1,0x12345 -> alu_func=1, alu_b=0x12345000 during EXEC; rsp_valid at accept+2, rsp_rd=1, rsp_value=0x12345000, dbg_data(1)=0x12345000.
- x1=0xFFFFFFF0, then SRAI x2,x1,4 -> rsp_value=0xFFFFFFFF. SRLI x3,x1,4 -> 0x0FFFFFFF. SLTU x4,x1,x0 -> 0. SLT x5,x1,x0 -> 1.
- ADDI x0,x0,5 -> rsp_value=5, rsp_rd=0, dbg_data(0)=0. ADDI x6,x0,-1 -> 0xFFFFFFFF (sign extension); SUB x7,x0,x6 -> 1.
- Illegal instr 0x0000007F -> rsp_illegal=1 at accept+1, no register changes, alu_func stays 0. OP with funct7=0100000 and f3=100 -> illegal.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp fields stable, instr_ready=0 throughout; release -> instr_ready=1 on the next cycle.
- Assert rst_n=0 during EXEC of ADDI x8,x0,7 -> x8 stays 0, rsp_valid=0, state IDLE, instr_ready=1 once rst_n deasserts.

Source files
------------

// File: rtl/alu_issue_seq_if.sv
// ---------------------------------------------------------------------------
// alu_issue_seq_if
//   Bundles every non-clock/reset signal of the ALU issue sequencer.
//
//   Channels:
//     instr_*  : instruction offer (valid/ready) plus the RV32I word.
//     alu_*    : ALU drive (func/a/b) and the combinational result (alu_out).
//     rsp_*    : completion response (valid/ready) with rd/value/illegal.
//     dbg_*    : register-file debug read port.
//
//   Modports:
//     master : the sequencer (drives ready, ALU operands, responses).
//     slave  : the environment (fetch buffer, ALU, response consumer).
// ---------------------------------------------------------------------------
interface alu_issue_seq_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [4:0]      alu_func;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_rd;
  logic [XLEN-1:0] rsp_value;
  logic            rsp_illegal;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    input  instr_valid, instr, alu_out, rsp_ready, dbg_addr,
    output instr_ready, alu_func, alu_a, alu_b,
           rsp_valid, rsp_rd, rsp_value, rsp_illegal, dbg_data
  );

  modport slave (
    output instr_valid, instr, alu_out, rsp_ready, dbg_addr,
    input  instr_ready, alu_func, alu_a, alu_b,
           rsp_valid, rsp_rd, rsp_value, rsp_illegal, dbg_data
  );
endinterface

// File: rtl/alu_issue_seq.sv
// ---------------------------------------------------------------------------
// alu_issue_seq
//   Sequential issue/writeback controller for RV32I OP, OP-IMM and LUI.
//   Accepts one instruction, decodes it and reads its operands from an
//   internal register file. It then drives the external combinational ALU
//   for one cycle, writes the result back to rd and reports completion on
//   a valid/ready response channel.
//
//   Ports:
//     clk    : clock, rising edge.
//     rst_n  : asynchronous active-low reset.
//     bus    : alu_issue_seq_if.master (instr, ALU, response and debug).
//
//   Flow: IDLE --accept legal--> EXEC --1 cycle--> RESP --rsp handshake--> IDLE
//         IDLE --accept illegal--> RESP
// ---------------------------------------------------------------------------
module alu_issue_seq #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_seq_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [4:0] FN_NOP  = 5'd0;
  localparam logic [4:0] FN_ADD  = 5'd1;
  localparam logic [4:0] FN_SUB  = 5'd2;
  localparam logic [4:0] FN_AND  = 5'd3;
  localparam logic [4:0] FN_OR   = 5'd4;
  localparam logic [4:0] FN_XOR  = 5'd5;
  localparam logic [4:0] FN_SLL  = 5'd6;
  localparam logic [4:0] FN_SRL  = 5'd7;
  localparam logic [4:0] FN_SRA  = 5'd8;
  localparam logic [4:0] FN_SLT  = 5'd9;
  localparam logic [4:0] FN_SLTU = 5'd10;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]      state_reg, state_next;
  logic [4:0]      func_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [4:0]      rsp_rd_reg;
  logic [XLEN-1:0] rsp_value_reg;
  logic            rsp_illegal_reg;

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] f3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] f7;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign f3     = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign f7     = bus.instr[31:25];

  // -------------------------------------------------------------------------
  // Register file: x0 is a constant, x1..x31 are individually reset so an
  // async reset clears the whole architectural state at once.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREGS];
  logic            wr_en;

  // Writeback happens on the EXEC edge; rd=0 is dropped here as well as by
  // x0 having no storage.
  assign wr_en = (state_reg == ST_EXEC) && (rsp_rd_reg != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf_q[gi] = '0;
      end else begin : g_reg
        localparam logic [4:0] IDX = 5'(gi);
        logic [XLEN-1:0] q_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q_reg <= '0;
          end else if (wr_en && (rsp_rd_reg == IDX)) begin
            q_reg <= bus.alu_out;
          end
        end

        assign rf_q[gi] = q_reg;
      end
    end
  endgenerate

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_val      = rf_q[rs1];
  assign rs2_val      = rf_q[rs2];
  assign bus.dbg_data = rf_q[bus.dbg_addr];

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  // base_func is the funct7=0000000 meaning of each funct3; alt_func is the
  // funct7=0100000 variant, which only exists for f3=000 (SUB) and 101 (SRA).
  logic [4:0] base_func;
  logic [4:0] alt_func;
  logic       alt_ok;

  always_comb begin
    base_func = FN_NOP;
    alt_func  = FN_NOP;
    alt_ok    = 1'b0;
    case (f3)
      3'b000: begin base_func = FN_ADD;  alt_func = FN_SUB; alt_ok = 1'b1; end
      3'b001:       base_func = FN_SLL;
      3'b010:       base_func = FN_SLT;
      3'b011:       base_func = FN_SLTU;
      3'b100:       base_func = FN_XOR;
      3'b101: begin base_func = FN_SRL;  alt_func = FN_SRA; alt_ok = 1'b1; end
      3'b110:       base_func = FN_OR;
      default:      base_func = FN_AND;
    endcase
  end

  logic [4:0]      dec_func;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_legal;
  logic            is_shift;

  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec_func  = FN_NOP;
    dec_a     = '0;
    dec_b     = '0;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = rs1_val;
        dec_b = rs2_val;
        if (f7 == F7_BASE) begin
          dec_func  = base_func;
          dec_legal = 1'b1;
        end else if ((f7 == F7_ALT) && alt_ok) begin
          dec_func  = alt_func;
          dec_legal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_a = rs1_val;
        if (is_shift) begin
          // Shift amount is unsigned; upper immediate bits are funct7.
          dec_b = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
          if (f7 == F7_BASE) begin
            dec_func  = base_func;
            dec_legal = 1'b1;
          end else if ((f7 == F7_ALT) && (f3 == 3'b101)) begin
            dec_func  = FN_SRA;
            dec_legal = 1'b1;
          end
        end else begin
          // No SUBI: f3=000 is always ADD regardless of immediate bits.
          dec_b     = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
          dec_func  = base_func;
          dec_legal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_func  = FN_ADD;
        dec_a     = '0;
        dec_b     = {bus.instr[31:12], 12'b0};
        dec_legal = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control
  // -------------------------------------------------------------------------
  logic accept;
  logic rsp_fire;

  assign accept   = (state_reg == ST_IDLE) && bus.instr_valid;
  assign rsp_fire = (state_reg == ST_RESP) && bus.rsp_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = dec_legal ? ST_EXEC : ST_RESP;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_fire) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      func_reg        <= FN_NOP;
      a_reg           <= '0;
      b_reg           <= '0;
      rsp_rd_reg      <= '0;
      rsp_value_reg   <= '0;
      rsp_illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            rsp_rd_reg      <= rd;
            rsp_value_reg   <= '0;
            rsp_illegal_reg <= !dec_legal;
            func_reg        <= dec_legal ? dec_func : FN_NOP;
            a_reg           <= dec_legal ? dec_a : '0;
            b_reg           <= dec_legal ? dec_b : '0;
          end
        end
        ST_EXEC: rsp_value_reg <= bus.alu_out;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: ALU operands are only presented during EXEC.
  // -------------------------------------------------------------------------
  logic in_exec;
  assign in_exec = (state_reg == ST_EXEC);

  assign bus.instr_ready = (state_reg == ST_IDLE);
  assign bus.alu_func    = in_exec ? func_reg : FN_NOP;
  assign bus.alu_a       = in_exec ? a_reg : '0;
  assign bus.alu_b       = in_exec ? b_reg : '0;
  assign bus.rsp_valid   = (state_reg == ST_RESP);
  assign bus.rsp_rd      = rsp_rd_reg;
  assign bus.rsp_value   = rsp_value_reg;
  assign bus.rsp_illegal = rsp_illegal_reg;

endmodule

// File: tb/tb_alu_issue_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_seq
//   Directed bench for alu_issue_seq. The bench models the external ALU and
//   checks decode, writeback, response timing, backpressure, x0 handling
//   and reset mid-operation against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_issue_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_issue_seq_if #(.XLEN(32)) bus ();

  alu_issue_seq #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational ALU.
  always_comb begin
    bus.alu_out = 32'h0;
    case (bus.alu_func)
      5'd1:  bus.alu_out = bus.alu_a + bus.alu_b;
      5'd2:  bus.alu_out = bus.alu_a - bus.alu_b;
      5'd3:  bus.alu_out = bus.alu_a & bus.alu_b;
      5'd4:  bus.alu_out = bus.alu_a | bus.alu_b;
      5'd5:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      5'd6:  bus.alu_out = bus.alu_a << bus.alu_b[4:0];
      5'd7:  bus.alu_out = bus.alu_a >> bus.alu_b[4:0];
      5'd8:  bus.alu_out = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      5'd9:  bus.alu_out = {31'h0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      5'd10: bus.alu_out = {31'h0, bus.alu_a < bus.alu_b};
      default: bus.alu_out = 32'h0;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_a;
  logic [31:0] last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int i = 0;
    while (!bus.instr_ready && i < 20) begin
      step();
      i++;
    end
    check({tag, ".ready"}, {31'h0, bus.instr_ready}, 32'h1);
  endtask

  task automatic dbg_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  // Issue one instruction with rsp_ready held high and check every phase.
  task automatic run_op(input string tag, input logic [31:0] w, input logic [4:0] exp_func,
                        input logic [4:0] exp_rd, input logic [31:0] exp_val, input logic exp_ill);
    wait_ready(tag);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hDEAD_BEEF;
    if (!exp_ill) begin
      check({tag, ".func"},  {27'h0, bus.alu_func},  {27'h0, exp_func});
      check({tag, ".early"}, {31'h0, bus.rsp_valid}, 32'h0);
      last_a = bus.alu_a;
      last_b = bus.alu_b;
      step();
    end else begin
      check({tag, ".nop"}, {27'h0, bus.alu_func}, 32'h0);
    end
    check({tag, ".valid"}, {31'h0, bus.rsp_valid},   32'h1);
    check({tag, ".rd"},    {27'h0, bus.rsp_rd},      {27'h0, exp_rd});
    check({tag, ".value"}, bus.rsp_value,            exp_val);
    check({tag, ".ill"},   {31'h0, bus.rsp_illegal}, {31'h0, exp_ill});
    $display("txn %-8s instr=%h rd=%0d value=%h illegal=%0b",
             tag, w, bus.rsp_rd, bus.rsp_value, bus.rsp_illegal);
    step();
    check({tag, ".done"}, {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.rsp_ready   = 1'b1;
    bus.dbg_addr    = 5'd0;
    step();
    step();

    // Reset values.
    check("rst.ready", {31'h0, bus.instr_ready}, 32'h1);
    check("rst.valid", {31'h0, bus.rsp_valid},   32'h0);
    check("rst.func",  {27'h0, bus.alu_func},    32'h0);
    check("rst.a",     bus.alu_a,                32'h0);
    check("rst.b",     bus.alu_b,                32'h0);
    check("rst.rd",    {27'h0, bus.rsp_rd},      32'h0);
    check("rst.value", bus.rsp_value,            32'h0);
    check("rst.ill",   {31'h0, bus.rsp_illegal}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    step();

    // LUI x1,0x12345
    run_op("lui", 32'h1234_50B7, 5'd1, 5'd1, 32'h1234_5000, 1'b0);
    check("lui.a", last_a, 32'h0);
    check("lui.b", last_b, 32'h1234_5000);
    dbg_check("lui.x1", 5'd1, 32'h1234_5000);

    // ADDI x1,x0,-16 then shifts and compares against x0
    run_op("addi_m16", 32'hFF00_0093, 5'd1,  5'd1, 32'hFFFF_FFF0, 1'b0);
    check("addi.b", last_b, 32'hFFFF_FFF0);
    run_op("srai",     32'h4040_D113, 5'd8,  5'd2, 32'hFFFF_FFFF, 1'b0);
    check("srai.b", last_b, 32'h0000_0004);
    run_op("srli",     32'h0040_D193, 5'd7,  5'd3, 32'h0FFF_FFFF, 1'b0);
    run_op("sltu",     32'h0000_B233, 5'd10, 5'd4, 32'h0000_0000, 1'b0);
    run_op("slt",      32'h0000_A2B3, 5'd9,  5'd5, 32'h0000_0001, 1'b0);
    run_op("xori",     32'h0FF0_C593, 5'd5,  5'd11, 32'hFFFF_FF0F, 1'b0);
    dbg_check("x2", 5'd2, 32'hFFFF_FFFF);
    dbg_check("x3", 5'd3, 32'h0FFF_FFFF);
    dbg_check("x5", 5'd5, 32'h0000_0001);

    // x0 destination and sign extension
    run_op("addi_x0",  32'h0050_0013, 5'd1, 5'd0, 32'h0000_0005, 1'b0);
    dbg_check("x0", 5'd0, 32'h0);
    run_op("addi_m1",  32'hFFF0_0313, 5'd1, 5'd6, 32'hFFFF_FFFF, 1'b0);
    run_op("sub",      32'h4060_03B3, 5'd2, 5'd7, 32'h0000_0001, 1'b0);
    dbg_check("x7", 5'd7, 32'h1);

    // Illegal encodings respond one cycle after accept with no write
    run_op("ill_opc",  32'h0000_007F, 5'd0, 5'd0, 32'h0, 1'b1);
    run_op("ill_xor",  32'h4020_C4B3, 5'd0, 5'd9, 32'h0, 1'b1);
    dbg_check("ill.x9", 5'd9, 32'h0);
    dbg_check("ill.x1", 5'd1, 32'hFFFF_FFF0);

    // Backpressure: ADD x10,x1,x6 held in RESP for 5 cycles
    wait_ready("stall");
    bus.rsp_ready   = 1'b0;
    bus.instr       = 32'h0060_8533;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall.valid", {31'h0, bus.rsp_valid},   32'h1);
      check("stall.value", bus.rsp_value,            32'hFFFF_FFEF);
      check("stall.rd",    {27'h0, bus.rsp_rd},      32'd10);
      check("stall.ready", {31'h0, bus.instr_ready}, 32'h0);
      step();
    end
    $display("txn stall    instr=00608533 rd=%0d value=%h held", bus.rsp_rd, bus.rsp_value);
    bus.rsp_ready = 1'b1;
    check("stall.same", {31'h0, bus.instr_ready}, 32'h0);
    step();
    check("stall.rel",  {31'h0, bus.instr_ready}, 32'h1);
    check("stall.drop", {31'h0, bus.rsp_valid},   32'h0);

    // Reset during EXEC of ADDI x8,x0,7
    bus.instr       = 32'h0070_0413;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    check("rstx.exec", {27'h0, bus.alu_func}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstx.valid", {31'h0, bus.rsp_valid},   32'h0);
    check("rstx.ready", {31'h0, bus.instr_ready}, 32'h1);
    check("rstx.func",  {27'h0, bus.alu_func},    32'h0);
    step();
    dbg_check("rstx.x8", 5'd8, 32'h0);
    dbg_check("rstx.x1", 5'd1, 32'h0);
    $display("txn rst_exec instr=00700413 aborted");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rstx.rel", {31'h0, bus.instr_ready}, 32'h1);

    // Controller recovers and executes normally
    run_op("addi_7", 32'h0070_0413, 5'd1, 5'd8, 32'h0000_0007, 1'b0);
    dbg_check("x8", 5'd8, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
